// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, holds it for
// LATENCY busy cycles, then completes with a one-cycle ack (data or error).
module dmem_responder #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              ready_o,
   output logic              ack_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic              stall_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                we_r;
   logic [31:0]         addr_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [DATA_W-1:0]   mem_r [DEPTH];

   logic                done_s;
   logic                err_s;
   logic                wr_en_s;
   logic [IDX_W-1:0]    idx_s;

   // Misaligned or beyond the storage array.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
   endfunction

   // Completion decode from the captured request.
   always_comb begin
      done_s  = 1'b0;
      err_s   = 1'b0;
      wr_en_s = 1'b0;
      idx_s   = addr_r[IDX_W+1:2];
      if (state_r == BUSY) begin
         done_s = (cnt_r == {CNT_W{1'b0}});
      end else begin
         done_s = 1'b0;
      end
      err_s   = addr_bad(addr_r);
      wr_en_s = done_s && we_r && !err_s;
   end

   // Pipeline freezes until the ack cycle.
   assign stall_o = req_i & ~ack_o;

   // Storage write port; the array itself is never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_s) begin
         mem_r[idx_s] <= wdata_r;
      end
   end

   // Request FSM with registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         we_r    <= 1'b0;
         addr_r  <= 32'd0;
         wdata_r <= {DATA_W{1'b0}};
         ready_o <= 1'b1;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         rdata_o <= {DATA_W{1'b0}};
      end else begin
         unique case (state_r)
            IDLE: begin
               ack_o <= 1'b0;
               err_o <= 1'b0;
               if (req_i) begin
                  we_r    <= we_i;
                  addr_r  <= addr_i;
                  wdata_r <= wdata_i;
                  cnt_r   <= CNT_INIT;
                  ready_o <= 1'b0;
                  state_r <= BUSY;
               end
            end
            BUSY: begin
               if (done_s) begin
                  state_r <= RESP;
                  ack_o   <= 1'b1;
                  err_o   <= err_s;
                  if (err_s) begin
                     rdata_o <= {DATA_W{1'b0}};
                  end else if (!we_r) begin
                     rdata_o <= mem_r[idx_s];
                  end
               end else begin
                  cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            RESP: begin
               // req_i still belongs to the completed request, so it is not sampled here.
               ack_o   <= 1'b0;
               err_o   <= 1'b0;
               ready_o <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               ack_o   <= 1'b0;
               err_o   <= 1'b0;
               ready_o <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_dmem_responder;

   localparam int LAT0 = 4;
   localparam int LAT1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req0, req1, we;
   logic [31:0] addr, wdata;
   logic        ready0, ack0, err0, stall0;
   logic        ready1, ack1, err1, stall1;
   logic [31:0] rdata0, rdata1;
   logic        sel;

   logic        ready_s, ack_s, err_s, stall_s;
   logic [31:0] rdata_s;
   assign ready_s = sel ? ready1 : ready0;
   assign ack_s   = sel ? ack1   : ack0;
   assign err_s   = sel ? err1   : err0;
   assign stall_s = sel ? stall1 : stall0;
   assign rdata_s = sel ? rdata1 : rdata0;

   dmem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(LAT0)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .ready_o(ready0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0), .stall_o(stall0)
   );

   dmem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(LAT1)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .ready_o(ready1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .stall_o(stall1)
   );

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_mem [2][256];
   logic [31:0] model_rdata [2];
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   // Drive one request (caller is just after a rising edge), check every cycle until ack.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic hold);
      exp_t e;
      int   s;
      int   lat;
      bit   bad;
      bit   got;
      s   = sel ? 1 : 0;
      lat = sel ? LAT1 : LAT0;
      bad = (a[1:0] != 2'b00) || (a >= 32'd1024);
      if (bad) begin
         model_rdata[s] = 32'd0;
         e.err = 1'b1;
      end else if (w) begin
         model_mem[s][a[9:2]] = d;
         e.err = 1'b0;
      end else begin
         model_rdata[s] = model_mem[s][a[9:2]];
         e.err = 1'b0;
      end
      e.rdata = model_rdata[s];
      sb.push_back(e);
      we = w; addr = a; wdata = d;
      if (sel) req1 = 1'b1; else req0 = 1'b1;
      got = 1'b0;
      for (int k = 0; k < lat + 4 && !got; k++) begin
         @(negedge clk);
         check($sformatf("ack@%h c%0d", a, k), 32'(ack_s), 32'(k == lat + 1));
         check($sformatf("stall@%h c%0d", a, k), 32'(stall_s), 32'(k != lat + 1));
         if (k <= 1) check($sformatf("ready@%h c%0d", a, k), 32'(ready_s), 32'(k == 0));
         if (ack_s && sb.size() > 0) begin
            got = 1'b1;
            e = sb.pop_front();
            check($sformatf("err@%h", a), 32'(err_s), 32'(e.err));
            check($sformatf("rdata@%h", a), rdata_s, e.rdata);
         end else begin
            check($sformatf("err_idle@%h c%0d", a, k), 32'(err_s), 32'd0);
         end
         @(posedge clk); #1;
      end
      check($sformatf("ack_seen@%h", a), 32'(got), 32'd1);
      if (!hold) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
   endtask

   initial begin
      sel = 1'b0; rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      we = 1'b0; addr = 32'd0; wdata = 32'd0;
      model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
      #12;
      check("rst_ready", 32'(ready0), 32'd1);
      check("rst_ack", 32'(ack0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      check("rst_rdata", rdata0, 32'd0);
      req0 = 1'b1; #1;
      check("rst_stall_req", 32'(stall0), 32'd1);
      req0 = 1'b0; #1;
      check("rst_stall_noreq", 32'(stall0), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 32'h10, 32'd0, 1'b0);

      // Back-to-back with req held continuously.
      issue(1'b1, 32'h0, 32'h1, 1'b1);
      issue(1'b1, 32'h4, 32'h2, 1'b1);
      issue(1'b0, 32'h0, 32'd0, 1'b1);
      issue(1'b0, 32'h4, 32'd0, 1'b0);

      issue(1'b0, 32'h13, 32'd0, 1'b0);
      issue(1'b1, 32'h12, 32'hFFFF_FFFF, 1'b0);
      issue(1'b0, 32'h10, 32'd0, 1'b0);

      issue(1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0);
      issue(1'b1, 32'h400, 32'h0BAD0BAD, 1'b0);
      issue(1'b0, 32'h3FC, 32'd0, 1'b0);

      // Reset in the second BUSY cycle of a store discards it.
      issue(1'b1, 32'h20, 32'h12345678, 1'b0);
      we = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555; req0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      check("mid_rst_ack", 32'(ack0), 32'd0);
      check("mid_rst_ready", 32'(ready0), 32'd1);
      check("mid_rst_rdata", rdata0, 32'd0);
      check("mid_rst_err", 32'(err0), 32'd0);
      check("mid_rst_stall", 32'(stall0), 32'd1);
      req0 = 1'b0;
      @(negedge clk);
      check("mid_rst_ack_hold", 32'(ack0), 32'd0);
      rst_n = 1'b1;
      model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
      @(posedge clk); #1;
      issue(1'b0, 32'h20, 32'd0, 1'b0);

      // Idle with no request.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("idle_stall%0d", i), 32'(stall0), 32'd0);
         check($sformatf("idle_ack%0d", i), 32'(ack0), 32'd0);
         check($sformatf("idle_ready%0d", i), 32'(ready0), 32'd1);
      end
      @(posedge clk); #1;

      sel = 1'b1;
      issue(1'b1, 32'h3F0, 32'h5A5A5A5A, 1'b0);
      issue(1'b0, 32'h3F0, 32'd0, 1'b0);
      issue(1'b0, 32'h3F1, 32'd0, 1'b0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
